// File: rtl/vs0_copy_engine_if.sv
// Wishbone pipelined bus bundles for the VS0 copy engine: master (DMA side) and
// slave (register file side), each with master/slave modports.
interface vs0_wbm_if #(
  parameter int MST_ADDR_W = 28
);
  logic [MST_ADDR_W-1:0] wbm_adr_o;
  logic [31:0]           wbm_dat_o;
  logic [31:0]           wbm_dat_i;
  logic                  wbm_we_o;
  logic [3:0]            wbm_sel_o;
  logic                  wbm_stb_o;
  logic                  wbm_ack_i;
  logic                  wbm_stall_i;
  logic                  wbm_cyc_o;
  logic                  wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i, wbm_stall_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i, wbm_stall_i, wbm_err_i
  );
endinterface

interface vs0_wbs_if #(
  parameter int SLV_ADDR_W = 18
);
  logic [SLV_ADDR_W-1:0] wbs_adr;
  logic [31:0]           wbs_dat_w;
  logic [31:0]           wbs_dat_r;
  logic [3:0]            wbs_sel;
  logic                  wbs_stall;
  logic                  wbs_cyc;
  logic                  wbs_stb;
  logic                  wbs_ack;
  logic                  wbs_we;
  logic                  wbs_err;

  modport master (
    output wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  wbs_dat_r, wbs_stall, wbs_ack, wbs_err
  );

  modport slave (
    input  wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output wbs_dat_r, wbs_stall, wbs_ack, wbs_err
  );
endinterface

// File: rtl/vs0_copy_engine.sv
// VS0 slot copy engine: register file on the slave port, single-outstanding word
// copier on the master port. Optional constant-fill mode under VS0_FILL_MODE_EN.
module vs0_copy_engine #(
  parameter int          MST_ADDR_W = 28,
  parameter int          SLV_ADDR_W = 18,
  parameter int          LEN_W      = 16,
  parameter int          NUM_IRQ    = 32,
  parameter logic [31:0] SIGNATURE  = 32'h0000510C
) (
  input  logic               sys_clk,
  input  logic               rst,
  vs0_wbm_if.master          wbm,
  vs0_wbs_if.slave           wbs,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

`ifdef VS0_FILL_MODE_EN
  // SRC doubles as the 32-bit fill pattern, so it keeps a full word
  localparam int SRC_W = 32;
`else
  localparam int SRC_W = MST_ADDR_W;
`endif

  logic [2:0]            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_aborted;
  logic                  r_abort_pend;
  logic                  r_done_ie;
  logic [SRC_W-1:0]      r_src;
  logic [MST_ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]      r_len;
  logic [NUM_IRQ-1:0]    r_mask;
  logic [MST_ADDR_W-1:0] r_src_p;
  logic [MST_ADDR_W-1:0] r_dst_p;
  logic [LEN_W-1:0]      r_cnt;
  logic [31:0]           r_buf;
  logic                  r_ack;
  logic [31:0]           r_dat_r;
  logic                  r_irq;
`ifdef VS0_FILL_MODE_EN
  logic                  r_fill;
  logic                  r_fill_p;
`endif

  logic                  w_req;
  logic                  w_wr;
  logic [2:0]            w_addr;
  logic [31:0]           w_wdat;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_stat_wr;
  logic                  w_fill_cfg;
  logic                  w_fill_run;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_req     = wbs.wbs_cyc & wbs.wbs_stb;
  assign w_wr      = w_req & wbs.wbs_we;
  assign w_addr    = wbs.wbs_adr[2:0];
  assign w_wdat    = wbs.wbs_dat_w;
  assign w_start   = w_wr && (w_addr == 3'd1) && w_wdat[0];
  assign w_abort   = w_wr && (w_addr == 3'd1) && w_wdat[1];
  assign w_stat_wr = w_wr && (w_addr == 3'd2);
  assign w_unused  = ^{wbs.wbs_sel, wbs.wbs_adr[SLV_ADDR_W-1:3]};

`ifdef VS0_FILL_MODE_EN
  assign w_fill_cfg = r_fill;
  assign w_fill_run = r_fill_p;
`else
  assign w_fill_cfg = 1'b0;
  assign w_fill_run = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      3'd0:    w_rdata = SIGNATURE;
      3'd1:    w_rdata = {28'd0, w_fill_cfg, r_done_ie, 2'b00};
      3'd2:    w_rdata = {28'd0, r_aborted, r_err, r_done, r_busy};
      3'd3:    w_rdata = 32'(r_src);
      3'd4:    w_rdata = 32'(r_dst);
      3'd5:    w_rdata = 32'(r_len);
      3'd6:    w_rdata = 32'(r_mask);
      3'd7:    w_rdata = 32'(irq_in & r_mask);
      default: w_rdata = '0;
    endcase
  end

  // Slave response: one registered ack per accepted strobe, read data alongside
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_dat_r <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_dat_r <= w_rdata;
    end
  end

  assign wbs.wbs_ack   = r_ack;
  assign wbs.wbs_dat_r = r_dat_r;
  assign wbs.wbs_stall = 1'b0;
  assign wbs.wbs_err   = 1'b0;

  // Configuration registers; the engine works from copies taken at START
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_done_ie <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_mask    <= '0;
`ifdef VS0_FILL_MODE_EN
      r_fill    <= 1'b0;
`endif
    end else if (w_wr) begin
      case (w_addr)
        3'd1: begin
          r_done_ie <= w_wdat[2];
`ifdef VS0_FILL_MODE_EN
          r_fill    <= w_wdat[3];
`endif
        end
        3'd3:    r_src  <= w_wdat[SRC_W-1:0];
        3'd4:    r_dst  <= w_wdat[MST_ADDR_W-1:0];
        3'd5:    r_len  <= w_wdat[LEN_W-1:0];
        3'd6:    r_mask <= w_wdat[NUM_IRQ-1:0];
        default: ;
      endcase
    end
  end

  // Copy engine and status; hardware sets are written after W1C so they win
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_src_p      <= '0;
      r_dst_p      <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
`ifdef VS0_FILL_MODE_EN
      r_fill_p     <= 1'b0;
`endif
    end else begin
      if (w_stat_wr) begin
        if (w_wdat[1]) r_done    <= 1'b0;
        if (w_wdat[2]) r_err     <= 1'b0;
        if (w_wdat[3]) r_aborted <= 1'b0;
      end
      if (w_abort && r_busy) r_abort_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_src_p      <= r_src[MST_ADDR_W-1:0];
              r_dst_p      <= r_dst;
              r_cnt        <= r_len;
              r_busy       <= 1'b1;
              r_abort_pend <= 1'b0;
`ifdef VS0_FILL_MODE_EN
              r_fill_p     <= r_fill;
`endif
              if (w_fill_cfg) begin
                r_buf   <= 32'(r_src);
                r_state <= S_WR_REQ;
              end else begin
                r_state <= S_RD_REQ;
              end
            end
          end
        end
        S_RD_REQ: begin
          if (!wbm.wbm_stall_i) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (wbm.wbm_err_i) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_err        <= 1'b1;
            r_abort_pend <= 1'b0;
          end else if (wbm.wbm_ack_i) begin
            r_buf   <= wbm.wbm_dat_i;
            r_state <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!wbm.wbm_stall_i) r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (wbm.wbm_err_i) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_err        <= 1'b1;
            r_abort_pend <= 1'b0;
          end else if (wbm.wbm_ack_i) begin
            r_dst_p <= r_dst_p + MST_ADDR_W'(1);
            if (!w_fill_run) r_src_p <= r_src_p + MST_ADDR_W'(1);
            r_cnt <= r_cnt - LEN_W'(1);
            if ((r_cnt == LEN_W'(1)) || r_abort_pend) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_abort_pend <= 1'b0;
              if (r_abort_pend) r_aborted <= 1'b1;
            end else begin
              r_state <= w_fill_run ? S_WR_REQ : S_RD_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbm.wbm_cyc_o = (r_state != S_IDLE);
  assign wbm.wbm_stb_o = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign wbm.wbm_we_o  = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
  assign wbm.wbm_sel_o = wbm.wbm_stb_o ? 4'hF : 4'h0;
  assign wbm.wbm_adr_o = ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT)) ? r_src_p : r_dst_p;
  assign wbm.wbm_dat_o = r_buf;

  always_ff @(posedge sys_clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (r_done & r_done_ie) | (|(irq_in & r_mask));
  end

  assign irq_out = r_irq;

endmodule

// File: doc/vs0_copy_engine.md
Name: vs0_copy_engine

Overview:
- Parametrised successor to the Virtual Socket 0 stub; occupies the VS0 crossbar slot with the same master/slave/irq connectivity.
- The slave port exposes a register file: signature, control, status, source, destination, length and an irq_in mask.
- The master port implements a single-outstanding word-copy engine: read one word from SRC, write it to DST, repeat LEN times.
- irq_out combines engine-done with the masked irq_in inputs.

Parameters:
- MST_ADDR_W, 28, master word-address width.
- SLV_ADDR_W, 18, slave word-address width; only bits [2:0] are decoded.
- LEN_W, 16, width of the LEN register and the word counter.
- NUM_IRQ, 32, number of irq_in lines.
- SIGNATURE, 32'h0000510C, value of register 0.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wbm_adr_o  out  MST_ADDR_W  master word address.
- wbm_dat_o  out  32  master write data.
- wbm_dat_i  in  32  master read data.
- wbm_we_o  out  1  master write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  ack.
- wbm_stall_i  in  1  stall.
- wbm_cyc_o  out  1  cycle.
- wbm_err_i  in  1  bus error.
- wbs_adr  in  SLV_ADDR_W  slave word address.
- wbs_dat_w  in  32  slave write data.
- wbs_dat_r  out  32  slave read data.
- wbs_sel  in  4  byte selects (ignored; full-word access only).
- wbs_stall  out  1  tied 0.
- wbs_cyc  in  1  cycle.
- wbs_stb  in  1  strobe.
- wbs_ack  out  1  ack.
- wbs_we  in  1  write enable.
- wbs_err  out  1  tied 0.
- irq_in  in  NUM_IRQ  system irqs.
- irq_out  out  1  combined irq.

Behaviour:
- Clocking/reset: one clock, sys_clk. Reset rst is synchronous and active-high.
- Reset values: all registers 0; FSM IDLE; wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o = 0; wbs_ack = 0; irq_out = 0.
- rst mid-transfer aborts immediately: cyc drops the next edge and no status bits are set.

Slave port:
- wbs_ack registered: asserted the cycle after wbs_stb & wbs_cyc, for one cycle per strobe.
- Write takes effect on that edge. wbs_dat_r is valid together with wbs_ack.
- Registers decoded on wbs_adr[2:0]; upper bits alias.
  - 0 SIGNATURE, RO.
  - 1 CTRL: bit0 START (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 DONE_IE (R/W).
  - 2 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); bit3 ABORTED (W1C).
  - 3 SRC, R/W, MST_ADDR_W bits.
  - 4 DST, R/W, MST_ADDR_W bits.
  - 5 LEN, R/W, LEN_W bits.
  - 6 IRQ_MASK, R/W, NUM_IRQ bits.
  - 7 IRQ_PEND, RO = irq_in & IRQ_MASK.
- Unused upper bits read 0.
- SRC/DST/LEN may be written while BUSY. The engine uses working copies latched at START, so such writes do not affect the running transfer.

FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - START with LEN != 0: latch src_p, dst_p, cnt; set BUSY; go to RD_REQ.
  - START with LEN == 0: set DONE the same edge, no bus activity.
  - START while BUSY is ignored.
- RD_REQ: cyc=1, stb=1, we=0, sel=4'hF, adr=src_p.
  - stall=0: go to RD_WAIT (stb=0, cyc held 1).
  - stall=1: hold.
- RD_WAIT:
  - ack: capture wbm_dat_i into buf; go to WR_REQ; cyc stays 1.
- WR_REQ: stb=1, we=1, sel=4'hF, dat=buf, adr=dst_p.
  - stall=0: go to WR_WAIT.
- WR_WAIT:
  - ack: src_p++, dst_p++, cnt--.
  - If cnt becomes 0, or an abort is pending: go to IDLE, cyc=0, BUSY=0, DONE=1; ABORTED=1 if aborted.
  - Otherwise go to RD_REQ.
- Bus error: err_i in RD_WAIT or WR_WAIT goes to IDLE with cyc=0, ERR=1, BUSY=0, DONE unchanged.
- ABORT while BUSY:
  - Sets abort_pending; the transfer stops only at the next WR_WAIT ack.
  - An outstanding bus cycle is never abandoned.
  - A pending abort during RD_WAIT still completes the write of that word.
  - ABORT in IDLE has no effect.
- Pointers wrap modulo 2^MST_ADDR_W.
- Per-word latency with no stall and single-cycle ack: 4 cycles.
- Simultaneous W1C of DONE and hardware set of DONE: the set wins.
- irq_out registered: (DONE & DONE_IE) | (|(irq_in & IRQ_MASK)), one-cycle latency.

Optional Feature:
- Macro VS0_FILL_MODE_EN.
- Defined:
  - CTRL bit3 FILL is R/W.
  - When FILL=1 at START, the FSM skips RD_REQ/RD_WAIT and writes the latched SRC register value as constant data to DST..DST+LEN-1.
  - src_p is not incremented. Per-word latency is 2 cycles.
- Undefined: CTRL bit3 reads 0, writes are ignored, and only copy mode exists.

Test Plan:
- Reset then read regs 0..7 -> 0x0000510C, then all zeros; wbs_ack exactly 1 cycle after each stb.
- SRC=0x100, DST=0x200, LEN=3, START; memory model returns 0xA0+addr -> words 0x200..0x202 = 0x1A0, 0x1A1, 0x1A2; BUSY→0; DONE=1; 12 cycles with zero-wait slave.
- LEN=0 START -> DONE=1 next cycle, wbm_cyc_o never asserted; with DONE_IE=1, irq_out=1; W1C DONE -> irq_out=0.
- LEN=8, ABORT during the 3rd word's RD_WAIT -> exactly 3 words written, ABORTED=1, DONE=1.
- wbm_err_i on the 2nd read -> cyc drops, ERR=1, DONE=0, one word written; stall held 5 cycles in RD_REQ -> adr and stb stable throughout.
- IRQ_MASK=0x10, irq_in=0x10 -> irq_out=1 one cycle later, IRQ_PEND=0x10; irq_in=0x20 -> irq_out=0.
- Under VS0_FILL_MODE_EN only: FILL=1, SRC=0xDEADBEEF, LEN=4 -> 4 writes of 0xDEADBEEF, no reads.
